// File: rtl/resonator_dds_hls_deadlock_reporter.sv
// resonator_dds_hls_deadlock_reporter: qualifies a sustained monitor block and streams a deadlock report
// Ports: clock/reset (sync, active-high); block_in/info_in from the deadlock monitor;
//   clear re-arms from HOLD; m_axis_* report stream (registered); deadlock sticky flag.
// Optional feature macro: RESONATOR_DDS_DEADLOCK_TS_EN adds a free-running timestamp
//   and a third report beat carrying it; without it the report is two beats.
module resonator_dds_hls_deadlock_reporter #(
  parameter int THRESHOLD = 1024,
  parameter int CNT_W = 16,
  parameter int INFO_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              block_in,
  input  logic [INFO_W-1:0] info_in,
  input  logic              clear,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              deadlock
);
  typedef enum logic [1:0] {ARM, SEND, HOLD} state_t;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(THRESHOLD - 1);
`ifdef RESONATOR_DDS_DEADLOCK_TS_EN
  localparam logic [1:0] LAST = 2'd2;
  logic [31:0] ts_q;
  logic [31:0] cap_ts_q;
`else
  localparam logic [1:0] LAST = 2'd1;
`endif
  state_t state_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic [INFO_W-1:0] cap_info_q;
  logic [1:0] beat_q;
  logic [31:0] next_data_d;
  // payload of the beat after the current one; beat0 is loaded at detection
  always_comb begin
`ifdef RESONATOR_DDS_DEADLOCK_TS_EN
    next_data_d = (beat_q == 2'd0) ? 32'(cap_info_q) : cap_ts_q;
`else
    next_data_d = 32'(cap_info_q);
`endif
  end
`ifdef RESONATOR_DDS_DEADLOCK_TS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q <= '0;
      cap_ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if (state_q == ARM && block_in && run_cnt_q == LIM) cap_ts_q <= ts_q;
    end
  end
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARM;
      run_cnt_q <= '0;
      cap_info_q <= '0;
      beat_q <= '0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      deadlock <= 1'b0;
    end else begin
      case (state_q)
        ARM: begin
          if (!block_in) run_cnt_q <= '0;
          else if (run_cnt_q != LIM) run_cnt_q <= run_cnt_q + CNT_W'(1);
          else begin
            run_cnt_q <= '0;
            cap_info_q <= info_in;
            beat_q <= '0;
            state_q <= SEND;
            m_axis_tdata <= 32'hDEADB10C;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast <= 1'b0;
            deadlock <= 1'b1;
          end
        end
        // tvalid is always high here, so tready alone marks a transfer
        SEND: begin
          if (m_axis_tready) begin
            if (beat_q == LAST) begin
              state_q <= HOLD;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast <= 1'b0;
              m_axis_tdata <= '0;
            end else begin
              beat_q <= beat_q + 2'd1;
              m_axis_tdata <= next_data_d;
              m_axis_tlast <= (beat_q + 2'd1) == LAST;
            end
          end
        end
        HOLD: begin
          if (clear) begin
            state_q <= ARM;
            run_cnt_q <= '0;
            deadlock <= 1'b0;
          end
        end
        default: state_q <= ARM;
      endcase
    end
  end
endmodule

// File: doc/resonator_dds_hls_deadlock_reporter.md
# resonator_dds_hls_deadlock_reporter

Consumer side of the HLS deadlock monitor: samples a monitor's `block` flag and its `axis_block_info` vector, qualifies a deadlock once `block` has been held for a programmable number of consecutive cycles, and emits a fixed-format report packet over an AXI4-Stream master. It also provides a sticky `deadlock` flag that host software clears. It sits beside each per-kernel deadlock monitor in the resonator DDS debug path, feeding the debug stream mux.

## Interface
Parameters:
- `THRESHOLD`, 1024: consecutive `block_in` cycles required to declare deadlock. Legal range 1 to 2^CNT_W−1.
- `CNT_W`, 16: width of the run-length counter.
- `INFO_W`, 4: width of `info_in`. Must be ≤ 32.

Ports:
- `clock` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `block_in` in 1: monitor block flag.
- `info_in` in INFO_W: monitor axis block info. Valid only while `block_in`=1.
- `clear` in 1: single-cycle pulse that re-arms the reporter from HOLD.
- `m_axis_tdata` out 32: report beat.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: last beat of the report.
- `deadlock` out 1: sticky deadlock-detected flag.

## Operation
- States:
  - ARM: counting.
  - SEND: streaming the report.
  - HOLD: report done, waiting for `clear`.
- ARM:
  - `run_cnt` increments each cycle `block_in`=1 and resets to 0 on any cycle `block_in`=0.
  - When `block_in`=1 and `run_cnt`==THRESHOLD−1, the same cycle:
    - captures `info_in` into `cap_info`,
    - captures the timestamp into `cap_ts`,
    - sets beat index to 0,
    - moves to SEND.
- Timestamp: free-running 32-bit counter. Reset to 0; increments every cycle; wraps 0xFFFFFFFF→0. Captured as-is.
- SEND beats:
  - beat0 = 0xDEADB10C.
  - beat1 = `cap_info` zero-extended to 32 bits.
  - beat2 = `cap_ts`.
  - `m_axis_tlast`=1 on the final beat only.
- AXI-Stream rules:
  - A beat transfers on `tvalid` && `tready`.
  - `tdata`/`tlast` are stable while `tvalid`=1 and `tready`=0.
  - `tvalid` never drops until the transfer completes.
- After the final beat transfers, the block moves to HOLD and `tvalid` falls.
- HOLD:
  - `block_in` is ignored.
  - `clear`=1 → ARM with `run_cnt`=0.
- `clear` in ARM or SEND is ignored. A report is never truncated.
- `deadlock` = 1 in SEND and HOLD, 0 in ARM.
- `reset` at any point, including mid-packet, forces ARM, zeroes all counters and captures, and drops `tvalid` immediately. No partial-packet recovery.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `deadlock`=0, state ARM, `run_cnt`=0, timestamp=0.
- Detection latency: `block_in` sampled high on cycles N … N+THRESHOLD−1 gives `tvalid`=1 and `deadlock`=1 on cycle N+THRESHOLD.
- With `tready` held at 1, the packet occupies cycles N+THRESHOLD … N+THRESHOLD+2 (3 beats). `tvalid`=0 on the following cycle.
- THRESHOLD=1: a single high sample triggers the report on the next cycle.
- `clear` sampled in HOLD gives `deadlock`=0 the next cycle. Counting restarts from the following `block_in` sample.
- `block_in` dropping on the threshold cycle itself: no detection, `run_cnt`→0.
- All outputs are registered. There is no combinational path from `m_axis_tready` to any output.

## Configuration
- Macro: `RESONATOR_DDS_DEADLOCK_TS_EN`.
- Defined:
  - the timestamp counter and `cap_ts` are instantiated,
  - the report is 3 beats,
  - `tlast` is on beat2.
- Undefined:
  - no timestamp counter or `cap_ts` registers,
  - the report is 2 beats (0xDEADB10C, info),
  - `tlast` is on beat1.
  - All other behaviour is identical.

## Test plan
Parameters THRESHOLD=8, INFO_W=4, macro defined unless stated.
- **Reset:** `reset` high 3 cycles, then low → all outputs 0; `deadlock` stays 0 with `block_in`=0 for 100 cycles.
- **Near miss:** `block_in`=1 for 7 cycles, 0 for 1 cycle, then 1 for 7 cycles → no `tvalid`, `deadlock`=0 throughout.
- **Full report:**
  - Stimulus: `block_in`=1 with `info_in`=4'hD for 8 cycles starting at timestamp 20; `tready`=1.
  - Required: beats 0xDEADB10C, 0x0000000D, 0x0000001B; `tlast` on the third beat only; `deadlock`=1 from the first beat.
- **Backpressure:** as in the full-report case but with `tready` toggling 0,0,1 repeatedly → each beat's `tdata`/`tlast` is held stable across the stalls; exactly 3 transfers occur.
- **Clear handling:**
  - `clear` pulsed during SEND → ignored; the packet completes.
  - `clear` pulsed in HOLD → `deadlock`=0 next cycle; a new 8-cycle block produces a second report.
- **Mid-packet reset:** `reset` asserted after beat1 transfers → `tvalid`=0 next cycle, no beat2. With the macro undefined, a normal report is 2 beats with `tlast` on 0x0000000D.
